// File: rtl/life_pkg.sv
// Shared constants, cell addressing and scheduler states for the 8x8 toroidal Life board.
// The board is held as four 16-cell quadrant words.
package life_pkg;

  localparam int BOARD_W = 8;
  localparam int QUAD_W  = 4;
  localparam int NQUAD   = 4;
  localparam int QCELLS  = QUAD_W * QUAD_W;
  localparam int WIN_W   = QUAD_W + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C0     = 3'd1,
    C1     = 3'd2,
    C2     = 3'd3,
    C3     = 3'd4,
    COMMIT = 3'd5
  } state_e;

  // Bit position of a cell inside a quadrant word.
  function automatic int cell_idx(input int col, input int row);
    return col * QUAD_W + row;
  endfunction

endpackage

// File: rtl/life_quad_next.sv
// Combinational B3/S23 next state for one 4x4 quadrant, given its 6x6 neighbourhood
// (one-cell border already wrapped). Window bit index is wx*WIN_W + wy.
module life_quad_next
  import life_pkg::*;
(
  input  logic [WIN_W*WIN_W-1:0] win_i,
  output logic [QCELLS-1:0]      next_o
);

  logic [3:0] cnt;

  always_comb begin
    next_o = '0;
    cnt    = '0;
    for (int c = 0; c < QUAD_W; c++) begin
      for (int r = 0; r < QUAD_W; r++) begin
        cnt = '0;
        for (int dc = 0; dc < 3; dc++) begin
          for (int dr = 0; dr < 3; dr++) begin
            if (!(dc == 1 && dr == 1)) begin
              cnt = cnt + 4'(win_i[(c + dc) * WIN_W + (r + dr)]);
            end
          end
        end
        next_o[cell_idx(c, r)] = (cnt == 4'd3) ||
                                 (win_i[(c + 1) * WIN_W + (r + 1)] && (cnt == 4'd2));
      end
    end
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Owns the Life board, serves the display read port and sequences seed loads and
// generation updates so the committed board only changes during vertical blanking.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int GEN_W  = 16,
  parameter int RATE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank_start,
  input  logic              run,
  input  logic [RATE_W-1:0] rate,
  input  logic              step_req,
  output logic              step_ack,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [1:0]        load_addr,
  input  logic [15:0]       load_data,
  input  logic [1:0]        disp_sel,
  output logic [15:0]       disp_alive,
  output logic              busy,
  output logic              gen_done,
  output logic [GEN_W-1:0]  generation
);

  // state | meaning
  // IDLE   | board stable, loads accepted unless a generation is pending
  // C0..C3 | next state of quadrant 0..3 written into the shadow copy
  // COMMIT | shadow copied to the board in one edge, generation advanced
  state_e state_q, state_d;

  logic [QCELLS-1:0] board_q  [NQUAD];
  logic [QCELLS-1:0] shadow_q [NQUAD];
  logic [RATE_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              pending_q, pending_d;
  logic              step_pend_q, step_pend_d;
  logic              gen_done_q, step_ack_q;

  logic [RATE_W-1:0] rate_max;
  logic              run_hit, step_hit, trigger, load_fire;
  logic              calc_en, commit;
  logic [1:0]        calc_q;
  logic [WIN_W*WIN_W-1:0] win;
  logic [QCELLS-1:0] quad_next;
  logic [2:0]        gx, gy;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending_q) state_d = C0;
      C0:      state_d = C1;
      C1:      state_d = C2;
      C2:      state_d = C3;
      C3:      state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    calc_en = 1'b0;
    commit  = 1'b0;
    calc_q  = 2'd0;
    unique case (state_q)
      C0:      begin busy = 1'b1; calc_en = 1'b1; calc_q = 2'd0; end
      C1:      begin busy = 1'b1; calc_en = 1'b1; calc_q = 2'd1; end
      C2:      begin busy = 1'b1; calc_en = 1'b1; calc_q = 2'd2; end
      C3:      begin busy = 1'b1; calc_en = 1'b1; calc_q = 2'd3; end
      COMMIT:  begin busy = 1'b1; commit = 1'b1; end
      default: ;
    endcase
    load_ready = (state_q == IDLE) && !pending_q;
  end

  // rate 0 behaves like rate 1; >= keeps a shrinking rate from skipping a wrap
  assign rate_max  = (rate == '0) ? '0 : rate - RATE_W'(1);
  assign run_hit   = run && (frame_cnt_q >= rate_max);
  assign step_hit  = vblank_start && load_ready && step_req && !step_pend_q;
  assign trigger   = vblank_start && load_ready && (run_hit || (step_req && !step_pend_q));
  assign load_fire = load_valid && load_ready;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (!run)              frame_cnt_d = '0;
    else if (vblank_start) frame_cnt_d = (frame_cnt_q >= rate_max) ? '0 : frame_cnt_q + RATE_W'(1);

    pending_d   = pending_q;
    step_pend_d = step_pend_q;
    gen_d       = gen_q;
    if (trigger)  pending_d   = 1'b1;
    if (step_hit) step_pend_d = 1'b1;
    if (commit) begin
      pending_d   = 1'b0;
      step_pend_d = 1'b0;
      gen_d       = gen_q + GEN_W'(1);
    end
  end

  // Wrapped 6x6 window around quadrant calc_q; 3-bit truncation gives mod 8.
  always_comb begin
    win = '0;
    gx  = '0;
    gy  = '0;
    for (int wx = 0; wx < WIN_W; wx++) begin
      for (int wy = 0; wy < WIN_W; wy++) begin
        gx = 3'(int'(calc_q[1]) * QUAD_W + wx + BOARD_W - 1);
        gy = 3'(int'(calc_q[0]) * QUAD_W + wy + BOARD_W - 1);
        win[wx * WIN_W + wy] = board_q[{gx[2], gy[2]}][cell_idx(int'(gx[1:0]), int'(gy[1:0]))];
      end
    end
  end

  life_quad_next u_quad_next (
    .win_i  (win),
    .next_o (quad_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      board_q     <= '{default: '0};
      shadow_q    <= '{default: '0};
      frame_cnt_q <= '0;
      gen_q       <= '0;
      pending_q   <= 1'b0;
      step_pend_q <= 1'b0;
      gen_done_q  <= 1'b0;
      step_ack_q  <= 1'b0;
    end else begin
      if (load_fire) board_q[load_addr] <= load_data;
      if (commit)    board_q <= shadow_q;
      if (calc_en)   shadow_q[calc_q] <= quad_next;
      frame_cnt_q <= frame_cnt_d;
      gen_q       <= gen_d;
      pending_q   <= pending_d;
      step_pend_q <= step_pend_d;
      gen_done_q  <= commit;
      step_ack_q  <= commit && step_pend_q;
    end
  end

  assign disp_alive = board_q[disp_sel];
  assign gen_done   = gen_done_q;
  assign step_ack   = step_ack_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Self-checking bench for life_gen_scheduler against a cell-array Life model.
module tb_life_gen_scheduler;

  localparam int GEN_W  = 16;
  localparam int RATE_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vblank_start;
  logic              run;
  logic [RATE_W-1:0] rate;
  logic              step_req;
  logic              step_ack;
  logic              load_valid;
  logic              load_ready;
  logic [1:0]        load_addr;
  logic [15:0]       load_data;
  logic [1:0]        disp_sel;
  logic [15:0]       disp_alive;
  logic              busy;
  logic              gen_done;
  logic [GEN_W-1:0]  generation;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit m_cell [8][8];
  int m_gen;

  life_gen_scheduler #(.GEN_W(GEN_W), .RATE_W(RATE_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vblank_start (vblank_start),
    .run          (run),
    .rate         (rate),
    .step_req     (step_req),
    .step_ack     (step_ack),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .disp_sel     (disp_sel),
    .disp_alive   (disp_alive),
    .busy         (busy),
    .gen_done     (gen_done),
    .generation   (generation)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) m_cell[x][y] = 1'b0;
    m_gen = 0;
  endtask

  task automatic model_set_quad(input int q, input logic [15:0] w);
    int qx, qy;
    qx = q / 2;
    qy = q % 2;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        m_cell[qx * 4 + col][qy * 4 + row] = w[col * 4 + row];
  endtask

  function automatic logic [15:0] model_get_quad(input int q);
    logic [15:0] w;
    int qx, qy;
    w  = '0;
    qx = q / 2;
    qy = q % 2;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        w[col * 4 + row] = m_cell[qx * 4 + col][qy * 4 + row];
    return w;
  endfunction

  task automatic model_step();
    bit nx [8][8];
    int n;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        n = 0;
        for (int dx = -1; dx <= 1; dx++)
          for (int dy = -1; dy <= 1; dy++)
            if (dx != 0 || dy != 0) n += int'(m_cell[(x + dx + 8) % 8][(y + dy + 8) % 8]);
        nx[x][y] = (n == 3) || (m_cell[x][y] && n == 2);
      end
    end
    m_cell = nx;
    m_gen  = (m_gen + 1) % 65536;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_quad(input logic [1:0] q, output logic [15:0] w);
    disp_sel = q;
    #1;
    w = disp_alive;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic load_quad(input logic [1:0] q, input logic [15:0] w);
    load_valid = 1'b1;
    load_addr  = q;
    load_data  = w;
    tick();
    load_valid = 1'b0;
    model_set_quad(int'(q), w);
  endtask

  // Step trigger at cycle T; lat is the cycle offset where gen_done was seen (-1: timeout).
  task automatic pulse_step(output int lat, output logic ack);
    lat = -1;
    ack = 1'b0;
    step_req     = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (gen_done) begin
        lat = i;
        ack = step_ack;
        break;
      end
      tick();
    end
    step_req = 1'b0;
  endtask

  task automatic vpulse(output logic done, output logic ack);
    done = 1'b0;
    ack  = 1'b0;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      done = done | gen_done;
      ack  = ack | step_ack;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] w;
    reset_n = 1'b0;
    tick();
    tick();
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== 16'h0) $display("FAIL reset_disp_q%0d: got %h expected 0000", q, w);
      else pass_cnt++;
    end
    total_cnt++;
    if (generation !== 16'd0) $display("FAIL reset_generation: got %0d expected 0", generation);
    else pass_cnt++;
    total_cnt++;
    if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b expected 1", load_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || gen_done !== 1'b0 || step_ack !== 1'b0)
      $display("FAIL reset_flags: got busy=%b gen_done=%b step_ack=%b expected 0 0 0",
               busy, gen_done, step_ack);
    else pass_cnt++;
    reset_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic test_blinker();
    logic [15:0] w;
    int lat;
    logic ack;
    do_reset();
    load_quad(2'd0, 16'h0070);
    pulse_step(lat, ack);
    model_step();
    total_cnt++;
    if (lat !== 7 || ack !== 1'b1) $display("FAIL blinker_latency: got lat=%0d ack=%b expected 7 1", lat, ack);
    else pass_cnt++;
    read_quad(2'd0, w);
    total_cnt++;
    if (w !== 16'h0222 || w !== model_get_quad(0)) $display("FAIL blinker_q0: got %h expected 0222", w);
    else pass_cnt++;
    total_cnt++;
    if (generation !== 16'd1) $display("FAIL blinker_gen: got %0d expected 1", generation);
    else pass_cnt++;
    tick();
    tick();
    pulse_step(lat, ack);
    model_step();
    read_quad(2'd0, w);
    total_cnt++;
    if (lat !== 7 || w !== 16'h0070 || w !== model_get_quad(0))
      $display("FAIL blinker_second: got lat=%0d q0=%h expected 7 0070", lat, w);
    else pass_cnt++;
    total_cnt++;
    if (generation !== 16'(m_gen)) $display("FAIL blinker_gen2: got %0d expected %0d", generation, m_gen);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_seam();
    logic [15:0] w;
    logic [15:0] exp_c [4];
    int lat;
    logic ack;
    exp_c[0] = 16'h0011; exp_c[1] = 16'h0000; exp_c[2] = 16'h1000; exp_c[3] = 16'h0000;
    do_reset();
    load_quad(2'd0, 16'h0003);
    load_quad(2'd1, 16'h0008);
    pulse_step(lat, ack);
    model_step();
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== exp_c[q] || w !== model_get_quad(q))
        $display("FAIL seam_q%0d: got %h expected %h", q, w, exp_c[q]);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_run_rate();
    logic [15:0] w;
    logic done, ack;
    do_reset();
    for (int q = 0; q < 4; q++) load_quad(2'(q), 16'($urandom));
    run  = 1'b1;
    rate = 4'd2;
    tick();
    for (int k = 1; k <= 6; k++) begin
      vpulse(done, ack);
      total_cnt++;
      if (done !== ((k % 2) == 0) || ack !== 1'b0)
        $display("FAIL run_rate2_pulse%0d: got done=%b ack=%b expected %b 0", k, done, ack, (k % 2) == 0);
      else pass_cnt++;
      if ((k % 2) == 0) model_step();
    end
    total_cnt++;
    if (generation !== 16'd3) $display("FAIL run_rate2_gen: got %0d expected 3", generation);
    else pass_cnt++;
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== model_get_quad(q)) $display("FAIL run_board_q%0d: got %h expected %h", q, w, model_get_quad(q));
      else pass_cnt++;
    end
    rate = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      vpulse(done, ack);
      model_step();
      total_cnt++;
      if (done !== 1'b1) $display("FAIL run_rate0_pulse%0d: got done=%b expected 1", k, done);
      else pass_cnt++;
    end
    total_cnt++;
    if (generation !== 16'd6) $display("FAIL run_rate0_gen: got %0d expected 6", generation);
    else pass_cnt++;
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== model_get_quad(q)) $display("FAIL run0_board_q%0d: got %h expected %h", q, w, model_get_quad(q));
      else pass_cnt++;
    end
    run = 1'b0;
    rate = 4'd1;
    tick();
  endtask

  task automatic test_collision();
    logic [15:0] w;
    do_reset();
    total_cnt++;
    if (load_ready !== 1'b1) $display("FAIL coll_ready_T: got %b expected 1", load_ready);
    else pass_cnt++;
    step_req     = 1'b1;
    vblank_start = 1'b1;
    load_valid   = 1'b1;
    load_addr    = 2'd0;
    load_data    = 16'h0070;
    tick();
    vblank_start = 1'b0;
    load_addr    = 2'd1;
    load_data    = 16'hFFFF;
    model_set_quad(0, 16'h0070);
    for (int i = 1; i <= 6; i++) begin
      total_cnt++;
      if (load_ready !== 1'b0) $display("FAIL coll_ready_T+%0d: got %b expected 0", i, load_ready);
      else pass_cnt++;
      tick();
    end
    load_valid = 1'b0;
    step_req   = 1'b0;
    model_step();
    total_cnt++;
    if (gen_done !== 1'b1 || step_ack !== 1'b1 || load_ready !== 1'b1)
      $display("FAIL coll_T+7: got gen_done=%b step_ack=%b load_ready=%b expected 1 1 1",
               gen_done, step_ack, load_ready);
    else pass_cnt++;
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== model_get_quad(q)) $display("FAIL coll_q%0d: got %h expected %h", q, w, model_get_quad(q));
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_reset_midupdate();
    logic [15:0] w;
    logic seen;
    do_reset();
    for (int q = 0; q < 4; q++) load_quad(2'(q), 16'($urandom) | 16'h0070);
    step_req     = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    tick();
    tick();
    tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_busy_C2: got %b expected 1", busy);
    else pass_cnt++;
    reset_n  = 1'b0;
    step_req = 1'b0;
    tick();
    reset_n = 1'b1;
    model_clear();
    total_cnt++;
    if (busy !== 1'b0 || gen_done !== 1'b0 || step_ack !== 1'b0 || generation !== 16'd0)
      $display("FAIL mid_reset_flags: got busy=%b gen_done=%b step_ack=%b gen=%0d expected 0 0 0 0",
               busy, gen_done, step_ack, generation);
    else pass_cnt++;
    for (int q = 0; q < 4; q++) begin
      read_quad(2'(q), w);
      total_cnt++;
      if (w !== 16'h0) $display("FAIL mid_reset_q%0d: got %h expected 0000", q, w);
      else pass_cnt++;
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | gen_done | step_ack | busy;
      tick();
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_reset_quiet: got activity=%b expected 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_random_steps();
    logic [15:0] w;
    int lat;
    logic ack;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int q = 0; q < 4; q++) load_quad(2'(q), 16'($urandom));
      for (int s = 0; s < 3; s++) begin
        pulse_step(lat, ack);
        model_step();
        total_cnt++;
        if (lat !== 7 || ack !== 1'b1)
          $display("FAIL rand%0d_step%0d_lat: got lat=%0d ack=%b expected 7 1", it, s, lat, ack);
        else pass_cnt++;
        for (int q = 0; q < 4; q++) begin
          read_quad(2'(q), w);
          total_cnt++;
          if (w !== model_get_quad(q))
            $display("FAIL rand%0d_step%0d_q%0d: got %h expected %h", it, s, q, w, model_get_quad(q));
          else pass_cnt++;
        end
        tick();
        tick();
      end
      total_cnt++;
      if (generation !== 16'(m_gen)) $display("FAIL rand%0d_gen: got %0d expected %0d", it, generation, m_gen);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    vblank_start = 1'b0;
    run          = 1'b0;
    rate         = 4'd1;
    step_req     = 1'b0;
    load_valid   = 1'b0;
    load_addr    = 2'd0;
    load_data    = 16'h0;
    disp_sel     = 2'd0;
    model_clear();
    test_reset();
    test_blinker();
    test_seam();
    test_run_rate();
    test_collision();
    test_reset_midupdate();
    test_random_steps();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
